// File: rtl/frame_buffer.sv
// Double-buffered RGB frame store feeding screen_controller. Pixel writes and the clear engine
// target the back bank; the display reads the top/bottom scan-row pixels of the front bank.
module frame_buffer #(
  parameter int COLS = 64,
  parameter int ROWS = 64,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int SW = RW - 1
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [CW-1:0] wr_x,
  input  logic [RW-1:0] wr_y,
  input  logic [2:0]    wr_rgb,
  input  logic          clr_req,
  input  logic [2:0]    clr_rgb,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          busy,
  input  logic          frame_done,
  input  logic          rd_en,
  input  logic [SW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [2:0]    rd_rgb_top,
  output logic [2:0]    rd_rgb_bot
);

  localparam int AW = CW + RW;
  localparam int HW = CW + SW;
  localparam int HALF = COLS * ROWS / 2;
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_PEND} state_t;

  state_t        state_q;
  logic          frontSel_q;
  logic          swapAck_q;
  logic [AW-1:0] clrCnt_q;
  logic [2:0]    clrRgb_q;
  logic [2:0]    rdTop_q;
  logic [2:0]    rdBot_q;

  // Each bank is split by the row MSB so one access yields both scan-row halves.
  logic [2:0] memTop [2*HALF];
  logic [2:0] memBot [2*HALF];

  logic          wrAccept;
  logic          memWe;
  logic          memHalf;
  logic [HW-1:0] memAddr;
  logic [2:0]    memData;

  assign wr_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign swap_ack   = swapAck_q;
  assign rd_rgb_top = rdTop_q;
  assign rd_rgb_bot = rdBot_q;
  assign wrAccept   = wr_valid & wr_ready;

  always_comb begin
    memWe   = 1'b0;
    memHalf = 1'b0;
    memAddr = '0;
    memData = '0;
    if (state_q == CLEAR) begin
      memWe   = 1'b1;
      memHalf = clrCnt_q[AW-1];
      memAddr = clrCnt_q[HW-1:0];
      memData = clrRgb_q;
    end else if (wrAccept) begin
      memWe   = 1'b1;
      memHalf = wr_y[RW-1];
      memAddr = {wr_y[SW-1:0], wr_x};
      memData = wr_rgb;
    end
  end

  always_ff @(posedge clk_in) begin
    if (memWe && !memHalf) memTop[{~frontSel_q, memAddr}] <= memData;
    if (memWe && memHalf)  memBot[{~frontSel_q, memAddr}] <= memData;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rdTop_q <= '0;
      rdBot_q <= '0;
    end else if (rd_en) begin
      rdTop_q <= memTop[{frontSel_q, rd_row, rd_col}];
      rdBot_q <= memBot[{frontSel_q, rd_row, rd_col}];
    end
  end

  // Swap only toggles on a frame_done seen while pending, so the panel never shows a torn frame.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frontSel_q <= 1'b0;
      swapAck_q  <= 1'b0;
      clrCnt_q   <= '0;
      clrRgb_q   <= '0;
    end else begin
      swapAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
            clrRgb_q <= clr_rgb;
          end else if (swap_req) begin
            state_q <= SWAP_PEND;
          end
        end
        CLEAR: begin
          clrCnt_q <= clrCnt_q + CNT_ONE;
          if (clrCnt_q == '1) state_q <= IDLE;
        end
        SWAP_PEND: begin
          if (frame_done) begin
            frontSel_q <= ~frontSel_q;
            swapAck_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: a bank model supplies expected read data, queued when a
// read is issued and compared when the registered read data appears.
module tb_frame_buffer;

  localparam int COLS = 64;
  localparam int ROWS = 64;
  localparam int CW = 6;
  localparam int RW = 6;
  localparam int SW = 5;
  localparam int NPIX = COLS * ROWS;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [CW-1:0] wr_x;
  logic [RW-1:0] wr_y;
  logic [2:0]    wr_rgb;
  logic          clr_req;
  logic [2:0]    clr_rgb;
  logic          swap_req;
  logic          swap_ack;
  logic          busy;
  logic          frame_done;
  logic          rd_en;
  logic [SW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [2:0]    rd_rgb_top;
  logic [2:0]    rd_rgb_bot;

  int total = 0;
  int bad = 0;

  logic [2:0] model [2][NPIX];
  logic       frontM;
  logic [2:0] expTopQ [$];
  logic [2:0] expBotQ [$];
  string      tagQ [$];
  logic [2:0] monTop;
  logic [2:0] monBot;
  string      monTag;

  frame_buffer dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .clr_req    (clr_req),
    .clr_rgb    (clr_rgb),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_rgb_top (rd_rgb_top),
    .rd_rgb_bot (rd_rgb_bot)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read data is registered, so it is compared just after the edge that captured rd_en.
  always @(posedge clk_in) begin
    if (rd_en && !rst) begin
      #1;
      if (expTopQ.size() == 0) begin
        checkOutput("sb_underflow", expTopQ.size(), 1);
      end else begin
        monTop = expTopQ.pop_front();
        monBot = expBotQ.pop_front();
        monTag = tagQ.pop_front();
        checkOutput({monTag, "_top"}, rd_rgb_top, monTop);
        checkOutput({monTag, "_bot"}, rd_rgb_bot, monBot);
      end
    end
  end

  task automatic pushRead(input int row, input int col, input string tag);
    rd_en  = 1'b1;
    rd_row = row[SW-1:0];
    rd_col = col[CW-1:0];
    expTopQ.push_back(model[frontM][row * COLS + col]);
    expBotQ.push_back(model[frontM][(row + ROWS / 2) * COLS + col]);
    tagQ.push_back(tag);
  endtask

  task automatic applyStimulus(input logic [2:0] rgb, input logic withSwap, input logic withWrites,
                               input string tag);
    int n;
    n = 0;
    clr_req  = 1'b1;
    clr_rgb  = rgb;
    swap_req = withSwap;
    @(negedge clk_in);
    clr_req  = 1'b0;
    swap_req = 1'b0;
    clr_rgb  = '0;
    wr_valid = withWrites;
    checkOutput({tag, "_wr_ready"}, wr_ready, 0);
    while (busy === 1'b1 && n < 5000) begin
      n++;
      wr_x   = n[5:0];
      wr_y   = n[11:6];
      wr_rgb = 3'b111;
      @(negedge clk_in);
    end
    wr_valid = 1'b0;
    checkOutput({tag, "_busy_cycles"}, n, 4096);
    for (int a = 0; a < NPIX; a++) model[!frontM][a] = rgb;
  endtask

  task automatic doSwap(input int delay, input bit probe, input int row, input int col,
                        input string tag);
    swap_req = 1'b1;
    @(negedge clk_in);
    swap_req = 1'b0;
    wr_valid = 1'b1;
    wr_x     = 6'd1;
    wr_y     = 6'd1;
    wr_rgb   = 3'b010;
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_wr_ready"}, wr_ready, 0);
    repeat (delay - 1) @(negedge clk_in);
    checkOutput({tag, "_ack_early"}, swap_ack, 0);
    frame_done = 1'b1;
    if (probe) pushRead(row, col, {tag, "_old"});
    @(negedge clk_in);
    frame_done = 1'b0;
    wr_valid   = 1'b0;
    frontM     = !frontM;
    checkOutput({tag, "_ack"}, swap_ack, 1);
    checkOutput({tag, "_busy_after"}, busy, 0);
    if (probe) pushRead(row, col, {tag, "_new"});
    @(negedge clk_in);
    rd_en = 1'b0;
    checkOutput({tag, "_ack_pulse"}, swap_ack, 0);
  endtask

  initial begin
    rst = 1'b0; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clr_req = 1'b0; clr_rgb = '0; swap_req = 1'b0; frame_done = 1'b0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    frontM = 1'b0;

    repeat (2) @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rst_swap_ack", swap_ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rd_top", rd_rgb_top, 0);
    checkOutput("rst_rd_bot", rd_rgb_bot, 0);
    @(negedge clk_in);
    rst = 1'b0;

    $display("[TB] clear to 100 with blocked writes, swap, read");
    applyStimulus(3'b100, 1'b0, 1'b1, "clr1");
    doSwap(10, 1'b0, 0, 0, "swap1");
    pushRead(3, 5, "rd_c5r3");
    @(negedge clk_in);
    rd_en = 1'b0;
    @(negedge clk_in);
    checkOutput("hold_top", rd_rgb_top, 3'b100);
    checkOutput("hold_bot", rd_rgb_bot, 3'b100);
    for (int i = 0; i < 32; i++) begin
      pushRead(i, (i * 7) % COLS, "sweep");
      @(negedge clk_in);
    end
    pushRead(1, 1, "blocked_px");
    @(negedge clk_in);
    rd_en = 1'b0;

    $display("[TB] top/bottom split");
    applyStimulus(3'b000, 1'b0, 1'b0, "clr2");
    wr_valid = 1'b1; wr_x = 6'd7; wr_y = 6'd2; wr_rgb = 3'b011;
    checkOutput("wr_ready_idle", wr_ready, 1);
    model[!frontM][2 * COLS + 7] = 3'b011;
    @(negedge clk_in);
    wr_y = 6'd34; wr_rgb = 3'b101;
    model[!frontM][34 * COLS + 7] = 3'b101;
    @(negedge clk_in);
    wr_valid = 1'b0;
    doSwap(4, 1'b1, 2, 7, "swap2");
    pushRead(2, 6, "nb_left");
    @(negedge clk_in);
    pushRead(2, 8, "nb_right");
    @(negedge clk_in);
    rd_en = 1'b0;

    $display("[TB] simultaneous requests");
    applyStimulus(3'b010, 1'b1, 1'b0, "clr_swap");
    frame_done = 1'b1;
    @(negedge clk_in);
    frame_done = 1'b0;
    checkOutput("dropped_swap_ack", swap_ack, 0);
    checkOutput("dropped_swap_busy", busy, 0);
    @(negedge clk_in);
    checkOutput("dropped_swap_ack2", swap_ack, 0);
    pushRead(2, 7, "no_swap");
    @(negedge clk_in);
    rd_en = 1'b0;

    swap_req = 1'b1; frame_done = 1'b1;
    @(negedge clk_in);
    swap_req = 1'b0; frame_done = 1'b0;
    checkOutput("same_cycle_busy", busy, 1);
    checkOutput("same_cycle_ack", swap_ack, 0);
    repeat (3) @(negedge clk_in);
    checkOutput("same_cycle_ack_later", swap_ack, 0);
    checkOutput("same_cycle_busy_later", busy, 1);
    frame_done = 1'b1;
    @(negedge clk_in);
    frame_done = 1'b0;
    frontM = !frontM;
    checkOutput("late_swap_ack", swap_ack, 1);
    pushRead(2, 7, "late_swap");
    @(negedge clk_in);
    rd_en = 1'b0;

    doSwap(3, 1'b0, 0, 0, "swap4");

    $display("[TB] reset mid-clear");
    clr_req = 1'b1; clr_rgb = 3'b110;
    @(negedge clk_in);
    clr_req = 1'b0; clr_rgb = '0;
    repeat (1000) @(negedge clk_in);
    checkOutput("busy_mid_clear", busy, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst2_busy", busy, 0);
    checkOutput("rst2_wr_ready", wr_ready, 1);
    checkOutput("rst2_rd_top", rd_rgb_top, 0);
    checkOutput("rst2_swap_ack", swap_ack, 0);
    frontM = 1'b0;
    for (int a = 0; a < 1000; a++) model[1][a] = 3'b110;
    @(negedge clk_in);
    rst = 1'b0;
    doSwap(3, 1'b0, 0, 0, "swap5");
    for (int a = 0; a <= 1000; a++) begin
      pushRead(a / COLS, a % COLS, "partial");
      @(negedge clk_in);
    end
    rd_en = 1'b0;
    @(negedge clk_in);
    checkOutput("sb_drain", expTopQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
